// File: rtl/cipher_stream_ctrl.sv
// cipher_stream_ctrl
//   Byte-serial front end for a combinational MSG_LEN-byte cipher core.
//   Input bytes are collected into a block buffer. Lowercase letters are
//   folded to uppercase for encrypt messages when NORM_UPPER is set. A short
//   message is filled with PAD_CHAR. The buffer is held on the core inputs
//   for CORE_LAT cycles, then the core result is captured and streamed out
//   one byte at a time.
//
// Ports
//   clk, rst          : clock, asynchronous active-high reset
//   mode              : 0 = encrypt, 1 = decrypt, taken with the first byte
//   in_data/in_valid/in_last/in_ready : byte-serial input stream
//   core_text_in      : registered block buffer to the core, byte i at [8i+7:8i]
//   core_mode         : mode of the block currently held by the controller
//   core_text_out     : core result, same byte packing
//   out_data/out_valid/out_last/out_ready : byte-serial output stream
//   busy              : low only when idle in LOAD with nothing collected
//   msg_count         : number of fully drained blocks, wraps at 16 bits
module cipher_stream_ctrl #(
  parameter int unsigned MSG_LEN    = 6,
  parameter int unsigned SEC_LEN    = 3,
  parameter int unsigned CORE_LAT   = 2,
  parameter bit          NORM_UPPER = 1'b1,
  parameter logic [7:0]  PAD_CHAR   = 8'h58
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  output logic                   in_ready,
  output logic [8*MSG_LEN-1:0]   core_text_in,
  output logic                   core_mode,
  input  logic [8*MSG_LEN-1:0]   core_text_out,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   busy,
  output logic [15:0]            msg_count
);

  localparam int unsigned IDX_W = (MSG_LEN > 2) ? $clog2(MSG_LEN) : 1;
  localparam int unsigned CNT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT + 1) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(MSG_LEN - 1);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(CORE_LAT - 1);

  // SEC_LEN belongs to the core instance; it is only range-checked here.
  if (MSG_LEN < 2 || CORE_LAT < 1 || SEC_LEN < 1) begin : g_param_check
    $error("cipher_stream_ctrl: MSG_LEN must be >= 2, CORE_LAT and SEC_LEN >= 1");
  end

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [IDX_W-1:0]     wr_idx;
  logic [IDX_W-1:0]     rd_idx;
  logic [CNT_W-1:0]     wait_cnt;
  logic [8*MSG_LEN-1:0] buffer;
  logic [8*MSG_LEN-1:0] result;

  logic                 accept;
  logic                 load_done;
  logic                 wait_done;
  logic                 drain_hs;
  logic                 msg_mode;
  logic [7:0]           in_byte;

  // The core only ever sees the registered buffer, never in_data directly.
  assign core_text_in = buffer;

  // The first byte of a message carries the live mode input; later bytes
  // follow the mode latched with that first byte.
  assign msg_mode = (wr_idx == '0) ? mode : core_mode;

  // Case folding for encrypt messages; decrypt input is passed untouched.
  always_comb begin
    in_byte = in_data;
    if (NORM_UPPER && !msg_mode && (in_data >= 8'h61) && (in_data <= 8'h7A)) begin
      in_byte = in_data - 8'd32;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and handshake strobes. Load and drain never overlap.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    load_done  = 1'b0;
    wait_done  = 1'b0;
    drain_hs   = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready  = 1'b1;
        busy      = (wr_idx != '0);
        accept    = in_valid;
        load_done = in_valid && (in_last || (wr_idx == LAST_IDX));
        if (load_done) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        wait_done = (wait_cnt == '0);
        if (wait_done) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        out_last  = (rd_idx == LAST_IDX);
        drain_hs  = out_ready;
        if (out_ready && (rd_idx == LAST_IDX)) begin
          state_next = LOAD;
        end
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  // Output byte select; zero whenever nothing is being offered.
  always_comb begin
    out_data = '0;
    if (state == DRAIN) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        if (IDX_W'(i) == rd_idx) begin
          out_data = result[8*i +: 8];
        end
      end
    end
  end

  // Datapath: buffer fill with padding, settle countdown, result capture,
  // drain pointer and completed-block counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx    <= '0;
      rd_idx    <= '0;
      wait_cnt  <= '0;
      buffer    <= '0;
      result    <= '0;
      core_mode <= 1'b0;
      msg_count <= '0;
    end else begin
      if (accept) begin
        if (wr_idx == '0) begin
          core_mode <= mode;
        end
        // Slots above the closing byte are padded on the same edge.
        for (int i = 0; i < MSG_LEN; i++) begin
          if (IDX_W'(i) == wr_idx) begin
            buffer[8*i +: 8] <= in_byte;
          end else if (load_done && (IDX_W'(i) > wr_idx)) begin
            buffer[8*i +: 8] <= PAD_CHAR;
          end
        end
        if (load_done) begin
          wr_idx   <= '0;
          wait_cnt <= WAIT_INIT;
        end else begin
          wr_idx <= wr_idx + 1'b1;
        end
      end

      if (state == WAIT) begin
        if (wait_done) begin
          result <= core_text_out;
          rd_idx <= '0;
        end else begin
          wait_cnt <= wait_cnt - 1'b1;
        end
      end

      if (drain_hs) begin
        if (rd_idx == LAST_IDX) begin
          msg_count <= msg_count + 16'd1;
        end else begin
          rd_idx <= rd_idx + 1'b1;
        end
      end
    end
  end

endmodule
